cpu4_ctrl: RTL and testbench
============================

CPU4_CTRL -- requirements
Module: cpu4_ctrl

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1; 1 = an illegal opcode/funct parks the FSM in HALT, 0 = it returns to FETCH.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset=0 forces the reset state immediately.
REQ-004 Op  input  6  instruction opcode from the instruction register.
REQ-005 Funct  input  6  R-type function field from the instruction register.
REQ-006 zero  input  1  ALU zero flag from the current cycle.
REQ-007 PCEn  output  1  PC register load enable.
REQ-008 InstrmemWr  output  1  data memory write strobe.
REQ-009 IRWrite  output  1  instruction register load enable.
REQ-010 RegDst  output  1  1 = rd, 0 = rt as write register.
REQ-011 RegWrite  output  1  register file write enable.
REQ-012 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-013 ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate shifted left 2.
REQ-014 MemOrReg  output  1  1 = memory data to WD3, 0 = ALUOut.
REQ-015 signext  output  1  1 = sign-extend immediate, 0 = zero-extend.
REQ-016 PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-017 ALUControl  output  11  one-hot: b0 ADD, b1 SUB, b2 AND, b3 OR, b4 XOR, b5 NOR, b6 SLT, b7 SLL, b8 SRL, b9 SRA, b10 LUI.
REQ-018 state  output  4  current FSM state encoding (debug).
REQ-019 illegal  output  1  sticky flag: an undecodable instruction was seen.

Function
REQ-020 The FSM SHALL have these states and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, HALT 15.
REQ-021 The FSM SHALL perform these transitions: FETCH->DECODE; DECODE->MEMADR (lw 100011, sw 101011), RTEX (Op 000000), BRANCH (beq 000100, bne 000101), IMMEX (addi 001000, andi 001100, ori 001101, lui 001111), JUMP (j 000010); MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; RTEX->ALUWB; IMMEX->IMMWB; MEMWB, MEMWR, ALUWB, IMMWB, BRANCH and JUMP->FETCH.
REQ-022 An unlisted Op in DECODE, or an unlisted Funct with Op=000000, SHALL set illegal and go to HALT if HALT_ON_ILLEGAL=1, else to FETCH.
REQ-023 HALT SHALL be absorbing until reset; all outputs in HALT SHALL be 0 except state=15 and illegal=1.
REQ-024 Outputs SHALL be a Moore decode of state, plus Op/Funct/zero where listed; every output not listed for a state SHALL be 0.
REQ-025 FETCH: IRWrite=1, PCEn=1, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=00.
REQ-026 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ADD, signext=1 (precomputes the branch target).
REQ-027 MEMADR: ALUSrcA=1, ALUSrcB=10, signext=1, ALUControl=ADD; MEMRD: none; MEMWB: RegWrite=1, RegDst=0, MemOrReg=1; MEMWR: InstrmemWr=1.
REQ-028 RTEX: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sll 000000, srl 000010, sra 000011.
REQ-029 ALUWB: RegWrite=1, RegDst=1, MemOrReg=0; IMMWB: RegWrite=1, RegDst=0, MemOrReg=0.
REQ-030 IMMEX: ALUSrcA=1, ALUSrcB=10; addi uses ADD with signext=1; andi uses AND, ori uses OR and lui uses LUI, each with signext=0.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSrc=01; PCEn SHALL equal zero for beq and ~zero for bne, evaluated combinationally in the same cycle.
REQ-032 JUMP: PCSrc=10, PCEn=1.
REQ-033 Every instruction SHALL take the following cycles, FETCH included: lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3.
REQ-034 ALUControl SHALL be exactly one-hot in every state except MEMRD, the write-back states, MEMWR, JUMP and HALT, where it SHALL be all zero.

Reset
REQ-035 While reset=0, state SHALL be FETCH (0), illegal SHALL be 0, and outputs SHALL be 0 (not the FETCH decode).
REQ-036 The first rising CLK edge with reset=1 SHALL stay in FETCH and assert the FETCH outputs; the FSM SHALL advance on the following edge.
REQ-037 Asserting reset mid-instruction SHALL abort the instruction; no RegWrite or InstrmemWr pulse SHALL follow in that cycle.

Verification
REQ-038 Reset, then Op=100011: state sequence 0,1,2,3,4,0; RegWrite=1 and MemOrReg=1 only in state 4.
REQ-039 Op=000100 with zero=1 in BRANCH: PCEn=1, PCSrc=01; repeat with zero=0: PCEn=0; Op=000101 with zero=0: PCEn=1.
REQ-040 Op=000000, Funct=100010: RTEX has ALUControl=11'h002, ALUSrcB=00; ALUWB has RegDst=1, RegWrite=1.
REQ-041 Op=001101: IMMEX has ALUControl=11'h008, signext=0; IMMWB has RegDst=0, RegWrite=1.
REQ-042 Op=111111 with HALT_ON_ILLEGAL=1: state 0,1,15, then stuck with illegal=1; reset low returns state=0 and illegal=0. With HALT_ON_ILLEGAL=0: state 0,1,0 and illegal=1.
REQ-043 reset dropped asynchronously in MEMWR (state 5): InstrmemWr falls to 0 before the next edge and state=0.

Source files
------------

// File: rtl/cpu4_ctrl.sv
// Multi-cycle MIPS-style control FSM: sequences fetch/decode/execute/write-back
// and decodes datapath controls from the current state, opcode, funct and zero.
module cpu4_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        zero,
    output logic        PCEn,
    output logic        InstrmemWr,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        MemOrReg,
    output logic        signext,
    output logic [1:0]  PCSrc,
    output logic [10:0] ALUControl,
    output logic [3:0]  state,
    output logic        illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [10:0] ALU_ADD = 11'h001;
    localparam logic [10:0] ALU_SUB = 11'h002;
    localparam logic [10:0] ALU_AND = 11'h004;
    localparam logic [10:0] ALU_OR  = 11'h008;
    localparam logic [10:0] ALU_XOR = 11'h010;
    localparam logic [10:0] ALU_NOR = 11'h020;
    localparam logic [10:0] ALU_SLT = 11'h040;
    localparam logic [10:0] ALU_SLL = 11'h080;
    localparam logic [10:0] ALU_SRL = 11'h100;
    localparam logic [10:0] ALU_SRA = 11'h200;
    localparam logic [10:0] ALU_LUI = 11'h400;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    state_t      state_q, state_d;
    logic        run_q;
    logic        illegal_q, illegal_d;
    logic        funct_ok;
    logic [10:0] funct_alu;
    logic        decode_bad;

    // run_q holds outputs at zero until the first edge after reset release
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100110: funct_alu = ALU_XOR;
            6'b100111: funct_alu = ALU_NOR;
            6'b101010: funct_alu = ALU_SLT;
            6'b000000: funct_alu = ALU_SLL;
            6'b000010: funct_alu = ALU_SRL;
            6'b000011: funct_alu = ALU_SRA;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        decode_bad = 1'b0;
        PCEn       = 1'b0;
        InstrmemWr = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        MemOrReg   = 1'b0;
        signext    = 1'b0;
        PCSrc      = 2'b00;
        ALUControl = '0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    state_d    = S_DECODE;
                    IRWrite    = 1'b1;
                    PCEn       = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUControl = ALU_ADD;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = ALU_ADD;
                    signext    = 1'b1;
                    case (Op)
                        OP_LW, OP_SW:                      state_d = S_MEMADR;
                        OP_RTYPE: if (funct_ok)            state_d = S_RTEX;
                                  else                     decode_bad = 1'b1;
                        OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = S_IMMEX;
                        OP_J:                              state_d = S_JUMP;
                        default:                           decode_bad = 1'b1;
                    endcase
                    if (decode_bad) begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                end
                S_MEMADR: begin
                    state_d    = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    signext    = 1'b1;
                    ALUControl = ALU_ADD;
                end
                S_MEMRD: state_d = S_MEMWB;
                S_MEMWB: begin
                    state_d  = S_FETCH;
                    RegWrite = 1'b1;
                    MemOrReg = 1'b1;
                end
                S_MEMWR: begin
                    state_d    = S_FETCH;
                    InstrmemWr = 1'b1;
                end
                S_RTEX: begin
                    state_d    = S_ALUWB;
                    ALUSrcA    = 1'b1;
                    ALUControl = funct_alu;
                end
                S_ALUWB: begin
                    state_d  = S_FETCH;
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    state_d    = S_FETCH;
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_SUB;
                    PCSrc      = 2'b01;
                    PCEn       = (Op == OP_BNE) ? ~zero : zero;
                end
                S_IMMEX: begin
                    state_d = S_IMMWB;
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (Op)
                        OP_ANDI: ALUControl = ALU_AND;
                        OP_ORI:  ALUControl = ALU_OR;
                        OP_LUI:  ALUControl = ALU_LUI;
                        default: begin
                            ALUControl = ALU_ADD;
                            signext    = 1'b1;
                        end
                    endcase
                end
                S_IMMWB: begin
                    state_d  = S_FETCH;
                    RegWrite = 1'b1;
                end
                S_JUMP: begin
                    state_d = S_FETCH;
                    PCSrc   = 2'b10;
                    PCEn    = 1'b1;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu4_ctrl.sv
// Self-checking bench for cpu4_ctrl: vector table, randomized instruction stream
// against an instruction-level model, and directed reset/illegal sequences.
module tb_cpu4_ctrl;

    typedef struct packed {
        logic        pcen;
        logic        memwr;
        logic        irwrite;
        logic        regdst;
        logic        regwrite;
        logic        alusrca;
        logic [1:0]  alusrcb;
        logic        memorreg;
        logic        signext;
        logic [1:0]  pcsrc;
        logic [10:0] alu;
        logic [3:0]  st;
        logic        ill;
    } outs_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          cyc;
        logic [3:0]  st2;
        logic [10:0] alu2;
        logic        pcen2;
    } vec_t;

    typedef int iq_t[$];

    logic CLK = 1'b0;
    logic reset = 1'b0;
    logic [5:0] Op = '0;
    logic [5:0] Funct = '0;
    logic zero = 1'b0;

    logic a_pcen, a_memwr, a_irwrite, a_regdst, a_regwrite, a_alusrca, a_memorreg, a_signext, a_ill;
    logic [1:0] a_alusrcb, a_pcsrc;
    logic [10:0] a_alu;
    logic [3:0] a_state;
    logic b_pcen, b_memwr, b_irwrite, b_regdst, b_regwrite, b_alusrca, b_memorreg, b_signext, b_ill;
    logic [1:0] b_alusrcb, b_pcsrc;
    logic [10:0] b_alu;
    logic [3:0] b_state;

    int checks = 0;
    int failures = 0;

    logic [5:0] r_functs [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                  6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011};
    logic [5:0] legal_ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                   6'b001000, 6'b001100, 6'b001101, 6'b001111, 6'b000010};

    cpu4_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .CLK(CLK), .reset(reset), .Op(Op), .Funct(Funct), .zero(zero),
        .PCEn(a_pcen), .InstrmemWr(a_memwr), .IRWrite(a_irwrite), .RegDst(a_regdst),
        .RegWrite(a_regwrite), .ALUSrcA(a_alusrca), .ALUSrcB(a_alusrcb), .MemOrReg(a_memorreg),
        .signext(a_signext), .PCSrc(a_pcsrc), .ALUControl(a_alu), .state(a_state), .illegal(a_ill)
    );

    cpu4_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut_noh (
        .CLK(CLK), .reset(reset), .Op(Op), .Funct(Funct), .zero(zero),
        .PCEn(b_pcen), .InstrmemWr(b_memwr), .IRWrite(b_irwrite), .RegDst(b_regdst),
        .RegWrite(b_regwrite), .ALUSrcA(b_alusrca), .ALUSrcB(b_alusrcb), .MemOrReg(b_memorreg),
        .signext(b_signext), .PCSrc(b_pcsrc), .ALUControl(b_alu), .state(b_state), .illegal(b_ill)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    function automatic outs_t outs_a();
        return {a_pcen, a_memwr, a_irwrite, a_regdst, a_regwrite, a_alusrca, a_alusrcb,
                a_memorreg, a_signext, a_pcsrc, a_alu, a_state, a_ill};
    endfunction

    function automatic outs_t outs_b();
        return {b_pcen, b_memwr, b_irwrite, b_regdst, b_regwrite, b_alusrca, b_alusrcb,
                b_memorreg, b_signext, b_pcsrc, b_alu, b_state, b_ill};
    endfunction

    // Expected controls for a given step of an instruction, from the per-step control lists
    function automatic outs_t exp_outs(input int st, input logic [5:0] op, input logic [5:0] fn,
                                       input logic z, input logic ill);
        outs_t o;
        o = '0;
        o.st = 4'(st);
        o.ill = ill;
        case (st)
            0:  begin o.irwrite = 1'b1; o.pcen = 1'b1; o.alusrcb = 2'b01; o.alu = 11'h001; end
            1:  begin o.alusrcb = 2'b11; o.alu = 11'h001; o.signext = 1'b1; end
            2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.signext = 1'b1; o.alu = 11'h001; end
            4:  begin o.regwrite = 1'b1; o.memorreg = 1'b1; end
            5:  o.memwr = 1'b1;
            6:  begin
                    o.alusrca = 1'b1;
                    for (int i = 0; i < 10; i++) if (r_functs[i] == fn) o.alu = 11'(1) << i;
                end
            7:  begin o.regwrite = 1'b1; o.regdst = 1'b1; end
            8:  begin
                    o.alusrca = 1'b1; o.alu = 11'h002; o.pcsrc = 2'b01;
                    o.pcen = (op == 6'b000100) ? z : ~z;
                end
            9:  begin
                    o.alusrca = 1'b1; o.alusrcb = 2'b10;
                    case (op)
                        6'b001000: begin o.alu = 11'h001; o.signext = 1'b1; end
                        6'b001100: o.alu = 11'h004;
                        6'b001101: o.alu = 11'h008;
                        default:   o.alu = 11'h400;
                    endcase
                end
            10: o.regwrite = 1'b1;
            11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    // Sequence of steps an instruction walks through, FETCH included
    function automatic iq_t path(input logic [5:0] op);
        iq_t q;
        q.push_back(0);
        q.push_back(1);
        case (op)
            6'b100011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
            6'b101011: begin q.push_back(2); q.push_back(5); end
            6'b000000: begin q.push_back(6); q.push_back(7); end
            6'b000100, 6'b000101: q.push_back(8);
            6'b000010: q.push_back(11);
            default:   begin q.push_back(9); q.push_back(10); end
        endcase
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("reset_outs_a", 32'(outs_a()), 32'(outs_t'('0)));
        chk("reset_outs_b", 32'(outs_b()), 32'(outs_t'('0)));
        tick();
        chk("reset_held_edge", 32'(outs_a()), 32'(outs_t'('0)));
        reset = 1'b1;
        #1;
        chk("release_pre_edge", 32'(outs_a()), 32'(outs_t'('0)));
        tick();
        chk("first_edge_fetch", 32'(outs_a()), 32'(exp_outs(0, Op, Funct, zero, 1'b0)));
    endtask

    vec_t vecs [22];
    iq_t p;
    logic [5:0] op, fn;
    int cyc;
    logic [3:0] st2;
    logic [10:0] alu2;
    logic pcen2;
    int lw_seq [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 4'd2,  11'h001, 1'b0};
        vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 4, 4'd2,  11'h001, 1'b0};
        vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 4'd6,  11'h001, 1'b0};
        vecs[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 4'd6,  11'h002, 1'b0};
        vecs[4]  = '{6'b000000, 6'b100100, 1'b0, 4, 4'd6,  11'h004, 1'b0};
        vecs[5]  = '{6'b000000, 6'b100101, 1'b0, 4, 4'd6,  11'h008, 1'b0};
        vecs[6]  = '{6'b000000, 6'b100110, 1'b0, 4, 4'd6,  11'h010, 1'b0};
        vecs[7]  = '{6'b000000, 6'b100111, 1'b0, 4, 4'd6,  11'h020, 1'b0};
        vecs[8]  = '{6'b000000, 6'b101010, 1'b0, 4, 4'd6,  11'h040, 1'b0};
        vecs[9]  = '{6'b000000, 6'b000000, 1'b0, 4, 4'd6,  11'h080, 1'b0};
        vecs[10] = '{6'b000000, 6'b000010, 1'b0, 4, 4'd6,  11'h100, 1'b0};
        vecs[11] = '{6'b000000, 6'b000011, 1'b0, 4, 4'd6,  11'h200, 1'b0};
        vecs[12] = '{6'b000100, 6'b000000, 1'b1, 3, 4'd8,  11'h002, 1'b1};
        vecs[13] = '{6'b000100, 6'b000000, 1'b0, 3, 4'd8,  11'h002, 1'b0};
        vecs[14] = '{6'b000101, 6'b000000, 1'b0, 3, 4'd8,  11'h002, 1'b1};
        vecs[15] = '{6'b000101, 6'b000000, 1'b1, 3, 4'd8,  11'h002, 1'b0};
        vecs[16] = '{6'b001000, 6'b000000, 1'b0, 4, 4'd9,  11'h001, 1'b0};
        vecs[17] = '{6'b001100, 6'b000000, 1'b0, 4, 4'd9,  11'h004, 1'b0};
        vecs[18] = '{6'b001101, 6'b000000, 1'b0, 4, 4'd9,  11'h008, 1'b0};
        vecs[19] = '{6'b001111, 6'b000000, 1'b0, 4, 4'd9,  11'h400, 1'b0};
        vecs[20] = '{6'b000010, 6'b000000, 1'b0, 3, 4'd11, 11'h000, 1'b1};
        vecs[21] = '{6'b000010, 6'b111111, 1'b1, 3, 4'd11, 11'h000, 1'b1};

        do_reset();

        for (int v = 0; v < 22; v++) begin
            Op = vecs[v].op; Funct = vecs[v].fn; zero = vecs[v].z;
            cyc = 0; st2 = '0; alu2 = '0; pcen2 = 1'b0;
            do begin
                tick();
                cyc++;
                if (cyc == 2) begin st2 = a_state; alu2 = a_alu; pcen2 = a_pcen; end
            end while (a_state != 4'd0 && cyc < 12);
            chk($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].cyc));
            chk($sformatf("vec%0d_state3", v), 32'(st2), 32'(vecs[v].st2));
            chk($sformatf("vec%0d_alu3", v), 32'(alu2), 32'(vecs[v].alu2));
            chk($sformatf("vec%0d_pcen3", v), 32'(pcen2), 32'(vecs[v].pcen2));
        end

        for (int n = 0; n < 150; n++) begin
            op = legal_ops[$urandom_range(0, 9)];
            fn = (op == 6'b000000) ? r_functs[$urandom_range(0, 9)] : 6'($urandom);
            Op = op; Funct = fn;
            p = path(op);
            foreach (p[k]) begin
                zero = 1'($urandom);
                #1;
                chk($sformatf("rand%0d_op%b_step%0d_a", n, op, k), 32'(outs_a()),
                    32'(exp_outs(p[k], op, fn, zero, 1'b0)));
                chk($sformatf("rand%0d_op%b_step%0d_b", n, op, k), 32'(outs_b()),
                    32'(exp_outs(p[k], op, fn, zero, 1'b0)));
                tick();
            end
        end

        Op = 6'b100011; Funct = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("lw_state_%0d", k), 32'(a_state), 32'(lw_seq[k]));
            chk($sformatf("lw_regwrite_%0d", k), 32'(a_regwrite), 32'(lw_seq[k] == 4));
            chk($sformatf("lw_memorreg_%0d", k), 32'(a_memorreg), 32'(lw_seq[k] == 4));
            tick();
        end

        do_reset();
        Op = 6'b101011;
        tick(); tick(); tick();
        #1;
        chk("sw_memwr_state", 32'(a_state), 32'd5);
        chk("sw_memwr_high", 32'(a_memwr), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_memwr_low", 32'(a_memwr), 32'd0);
        chk("abort_state", 32'(a_state), 32'd0);
        chk("abort_outs", 32'(outs_a()), 32'(outs_t'('0)));

        for (int c = 0; c < 2; c++) begin
            Op = (c == 0) ? 6'b111111 : 6'b000000;
            Funct = (c == 0) ? 6'b100000 : 6'b111111;
            do_reset();
            tick();
            chk($sformatf("ill%0d_decode_a", c), 32'(a_state), 32'd1);
            chk($sformatf("ill%0d_decode_b", c), 32'(b_state), 32'd1);
            tick();
            chk($sformatf("ill%0d_halt_a", c), 32'(outs_a()), 32'(exp_outs(15, Op, Funct, zero, 1'b1)));
            chk($sformatf("ill%0d_fetch_b", c), 32'(outs_b()), 32'(exp_outs(0, Op, Funct, zero, 1'b1)));
            Op = 6'b000010;
            for (int k = 0; k < 4; k++) begin
                zero = 1'($urandom);
                tick();
                chk($sformatf("ill%0d_stuck%0d_a", c, k), 32'(outs_a()),
                    32'(exp_outs(15, Op, Funct, zero, 1'b1)));
                chk($sformatf("ill%0d_sticky%0d_b", c, k), 32'(b_ill), 32'd1);
            end
            reset = 1'b0;
            #1;
            chk($sformatf("ill%0d_reset_a", c), 32'(outs_a()), 32'(outs_t'('0)));
            chk($sformatf("ill%0d_reset_b", c), 32'(b_ill), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
